// File: rtl/blink_hex_bank_if.sv
// rtl/blink_hex_bank_if.sv - digit value/mode/wake/sync inputs and hex/phase outputs of the blink bank
interface blink_hex_bank_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] values;
  logic [2*DIGITS-1:0] mode;
  logic [DIGITS-1:0]   wake;
  logic                sync;
  logic [7*DIGITS-1:0] hex;
  logic                phase;

  // Controller side: drives digit contents and blink controls.
  modport master (
    output values, mode, wake, sync,
    input  hex, phase
  );

  // Display bank side.
  modport slave (
    input  values, mode, wake, sync,
    output hex, phase
  );
endinterface

// File: rtl/blink_hex_bank.sv
// rtl/blink_hex_bank.sv - multi-digit 7-segment driver with shared blink prescaler and per-digit wake
module blink_hex_bank #(
  parameter int DIGITS      = 4,
  parameter int HALF_PERIOD = 4096,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic           clk_i,
  input  logic           reset_i,
  blink_hex_bank_if.slave bus
);

  localparam int              CW    = (HALF_PERIOD > 2) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0]   LAST  = CW'(HALF_PERIOD - 1);
  localparam logic [6:0]      BLANK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_WAKE = 2'd2
  } state_t;

  logic [CW-1:0]       count_q, count_d;
  logic                phase_q, phase_d;
  logic                tick;
  state_t              state_q [DIGITS];
  state_t              state_d [DIGITS];
  logic [7*DIGITS-1:0] hex_q, hex_d;

  // Segment pattern {g,f,e,d,c,b,a} for a hex nibble, polarity applied at the end.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return (ACTIVE_LOW != 0) ? ~g : g;
  endfunction

  // Prescaler, phase and per-digit next state; outputs are derived from the state after this edge.
  always_comb begin
    logic [1:0] m;
    logic       lit_want;
    tick    = (count_q == LAST) & ~bus.sync;
    count_d = count_q + CW'(1);
    phase_d = phase_q;
    hex_d   = '0;
    m        = 2'b00;
    lit_want = 1'b0;
    if (bus.sync) begin
      // sync wins over a coincident tick: restart in the lit half
      count_d = '0;
      phase_d = 1'b1;
    end else if (tick) begin
      count_d = '0;
      phase_d = ~phase_q;
    end
    for (int i = 0; i < DIGITS; i++) begin
      state_d[i] = ST_OFF;
      m          = bus.mode[2*i +: 2];
      lit_want   = (m == 2'b01) ? phase_d : ~phase_d;
      case (m)
        2'b00: state_d[i] = ST_ON;
        2'b10: state_d[i] = ST_OFF;
        default: begin
          if (lit_want)
            state_d[i] = ST_ON;
          else if (state_q[i] == ST_WAKE && !tick && !bus.sync)
            state_d[i] = ST_WAKE;
          else if (bus.wake[i])
            state_d[i] = ST_WAKE;
          else
            state_d[i] = ST_OFF;
        end
      endcase
      hex_d[7*i +: 7] = (state_d[i] != ST_OFF) ? glyph(bus.values[4*i +: 4]) : BLANK;
    end
  end

  // State, prescaler and registered segment outputs; reset blanks every digit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      phase_q <= 1'b1;
      hex_q   <= {DIGITS{BLANK}};
      for (int i = 0; i < DIGITS; i++) state_q[i] <= ST_OFF;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      hex_q   <= hex_d;
      for (int i = 0; i < DIGITS; i++) state_q[i] <= state_d[i];
    end
  end

  assign bus.hex   = hex_q;
  assign bus.phase = phase_q;

endmodule

// File: tb/tb_blink_hex_bank.sv
// tb/tb_blink_hex_bank.sv - directed self-checking bench for blink_hex_bank
module tb_blink_hex_bank;

  localparam logic [6:0] BL = 7'h7F;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   e        = 0;

  logic [6:0] g [16];

  blink_hex_bank_if #(.DIGITS(4)) bus ();

  blink_hex_bank #(
    .DIGITS(4),
    .HALF_PERIOD(4),
    .ACTIVE_LOW(1)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] mk(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic chk_hex(input string tag, input logic [27:0] exp_hex);
    checks++;
    assert (bus.hex === exp_hex) else begin
      failures++;
      $error("FAIL %s hex=%h expected=%h (e=%0d)", tag, bus.hex, exp_hex, e);
    end
  endtask

  task automatic chk_phase(input string tag, input logic exp_ph);
    checks++;
    assert (bus.phase === exp_ph) else begin
      failures++;
      $error("FAIL %s phase=%b expected=%b (e=%0d)", tag, bus.phase, exp_ph, e);
    end
  endtask

  // Expected view for mode {00,10,00,01} with values 3210 and no wake in effect.
  task automatic chk_gen(input string tag);
    logic p;
    p = ((e / 4) % 2 == 0);
    chk_phase(tag, p);
    chk_hex(tag, mk(g[3], BL, g[1], p ? g[0] : BL));
  endtask

  initial begin
    logic p;
    g = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    reset      = 1'b1;
    bus.values = 16'h3210;
    bus.mode   = 8'h00;
    bus.wake   = 4'h0;
    bus.sync   = 1'b0;

    // 1: reset then steady glyphs
    step(); e = 0;
    chk_hex("reset_hex", mk(BL, BL, BL, BL));
    chk_phase("reset_phase", 1'b1);
    reset = 1'b0;
    step();
    chk_hex("steady_hex", mk(g[3], g[2], g[1], g[0]));
    chk_phase("steady_phase", 1'b1);

    // 2: digit0 blinks 4 lit / 4 dark
    bus.mode = 8'b00_00_00_01;
    while (e < 17) begin
      step();
      p = ((e / 4) % 2 == 0);
      chk_phase("blink_phase", p);
      chk_hex("blink_hex", mk(g[3], g[2], g[1], p ? g[0] : BL));
    end

    // 3: digit1 antiphase against digit0
    bus.mode = 8'b00_00_11_01;
    for (int k = 0; k < 8; k++) begin
      step();
      p = ((e / 4) % 2 == 0);
      chk_phase("anti_phase", p);
      chk_hex("anti_hex", mk(g[3], g[2], p ? BL : g[1], p ? g[0] : BL));
    end

    // 4: wake on 2nd clk of dark phase; digit2 blank ignores wake
    bus.mode = 8'b00_10_00_01;
    while (e % 8 != 4) step();
    chk_hex("dark_hex", mk(g[3], BL, g[1], BL));
    chk_phase("dark_phase", 1'b0);
    bus.wake = 4'b0101;
    step();
    bus.wake = 4'h0;
    chk_hex("wake_hex", mk(g[3], BL, g[1], g[0]));
    for (int k = 0; k < 6; k++) begin
      step();
      chk_hex("wake_hold", mk(g[3], BL, g[1], g[0]));
    end
    step();
    chk_hex("wake_end", mk(g[3], BL, g[1], BL));
    chk_phase("wake_end_phase", 1'b0);

    // wake sampled on the tick edge into dark holds the whole dark half
    while (e % 8 != 3) step();
    bus.wake = 4'b0001;
    step();
    bus.wake = 4'h0;
    chk_phase("tickwake_phase", 1'b0);
    chk_hex("tickwake_hex", mk(g[3], BL, g[1], g[0]));
    for (int k = 0; k < 7; k++) begin
      step();
      chk_hex("tickwake_hold", mk(g[3], BL, g[1], g[0]));
    end
    step();
    chk_hex("tickwake_end", mk(g[3], BL, g[1], BL));

    // leaving blink mode clears WAKE
    bus.wake = 4'b0001;
    step();
    bus.wake = 4'h0;
    chk_hex("clr_wake", mk(g[3], BL, g[1], g[0]));
    bus.mode = 8'b00_10_00_10;
    step();
    chk_hex("clr_blank", mk(g[3], BL, g[1], BL));
    bus.mode = 8'b00_10_00_01;
    step();
    chk_hex("clr_stays_dark", mk(g[3], BL, g[1], BL));
    step();
    chk_gen("clr_relit");

    // 5: sync mid-dark phase, then sync coincident with a tick in the lit half
    while (e % 8 != 5) step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    e = 0;
    chk_phase("sync_phase", 1'b1);
    chk_hex("sync_hex", mk(g[3], BL, g[1], g[0]));
    while (e < 3) begin
      step();
      chk_gen("sync_run");
    end
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    e = 0;
    chk_phase("synctick_phase", 1'b1);
    chk_hex("synctick_hex", mk(g[3], BL, g[1], g[0]));
    while (e < 9) begin
      step();
      chk_gen("synctick_run");
    end

    // 6: reset mid-blink with wake held high
    step(); step();
    reset    = 1'b1;
    bus.wake = 4'hF;
    step();
    chk_hex("rst2_hex", mk(BL, BL, BL, BL));
    chk_phase("rst2_phase", 1'b1);
    reset    = 1'b0;
    bus.wake = 4'h0;
    e = 0;
    step();
    chk_gen("rst2_after");

    // decoder coverage: remaining glyphs, value change visible at next edge
    bus.mode   = 8'h00;
    bus.values = 16'hFEDC;
    step();
    chk_hex("glyph_fedc", mk(g[15], g[14], g[13], g[12]));
    bus.values = 16'hBA98;
    step();
    chk_hex("glyph_ba98", mk(g[11], g[10], g[9], g[8]));
    bus.values = 16'h7654;
    step();
    chk_hex("glyph_7654", mk(g[7], g[6], g[5], g[4]));
    bus.mode = 8'hAA;
    step();
    chk_hex("all_blank", mk(BL, BL, BL, BL));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
